// File: rtl/ram_frmpool_banked.sv
// Banked frame-pool buffer: NUM_BANK low-order-interleaved single-port banks behind one
// read and one write port; same-bank collisions use fixed priority with starvation override.
module ram_frmpool_banked #(
  parameter int unsigned BANK_BIT       = 2,
  parameter int unsigned NUM_BANK       = 2**BANK_BIT,
  parameter int unsigned BANK_DEPTH_BIT = 6,
  parameter int unsigned SRAM_WIDTH     = 28,
  parameter int unsigned ADDR_BIT       = BANK_DEPTH_BIT + BANK_BIT,
  parameter bit          WR_PRIORITY    = 1'b1,
  parameter int unsigned STARVE_MAX     = 3,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_req,
  output logic                  wr_ready,
  input  logic [ADDR_BIT-1:0]   wr_addr,
  input  logic [SRAM_WIDTH-1:0] wr_data,
  input  logic                  rd_req,
  output logic                  rd_ready,
  input  logic [ADDR_BIT-1:0]   rd_addr,
  output logic                  rd_valid,
  output logic [SRAM_WIDTH-1:0] rd_data,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [BANK_BIT-1:0]       wr_bank, rd_bank;
  logic [BANK_DEPTH_BIT-1:0] wr_row, rd_row;
  logic                      collision, wr_wins, wr_fire, rd_fire;

  logic [3:0]            wr_starve_q, wr_starve_d;
  logic [3:0]            rd_starve_q, rd_starve_d;
  logic [CNT_WIDTH-1:0]  conflict_cnt_q, conflict_cnt_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [SRAM_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [NUM_BANK-1:0]   bank_we;
  logic [SRAM_WIDTH-1:0] bank_word [NUM_BANK];

  assign wr_bank = wr_addr[BANK_BIT-1:0];
  assign wr_row  = wr_addr[ADDR_BIT-1:BANK_BIT];
  assign rd_bank = rd_addr[BANK_BIT-1:0];
  assign rd_row  = rd_addr[ADDR_BIT-1:BANK_BIT];

  // The default loser wins once its starvation counter has hit the limit.
  always_comb begin
    collision = wr_req && rd_req && (wr_bank == rd_bank);
    if (WR_PRIORITY) wr_wins = (rd_starve_q != STARVE_LIM);
    else             wr_wins = (wr_starve_q == STARVE_LIM);
    wr_fire = wr_req && (!collision || wr_wins);
    rd_fire = rd_req && (!collision || !wr_wins);
  end

  assign wr_ready = wr_fire;
  assign rd_ready = rd_fire;

  always_comb begin
    wr_starve_d = wr_starve_q;
    if (wr_fire)
      wr_starve_d = '0;
    else if (collision && (wr_starve_q != STARVE_LIM))
      wr_starve_d = wr_starve_q + 4'd1;

    rd_starve_d = rd_starve_q;
    if (rd_fire)
      rd_starve_d = '0;
    else if (collision && (rd_starve_q != STARVE_LIM))
      rd_starve_d = rd_starve_q + 4'd1;

    conflict_cnt_d = conflict_cnt_q;
    if (collision && (conflict_cnt_q != '1))
      conflict_cnt_d = conflict_cnt_q + CNT_WIDTH'(1);

    rd_valid_d = rd_fire;
    rd_data_d  = rd_fire ? bank_word[rd_bank] : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_starve_q    <= '0;
      rd_starve_q    <= '0;
      conflict_cnt_q <= '0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      wr_starve_q    <= wr_starve_d;
      rd_starve_q    <= rd_starve_d;
      conflict_cnt_q <= conflict_cnt_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
    end
  end

  always_comb begin
    bank_we          = '0;
    bank_we[wr_bank] = wr_fire;
  end

  // Arbitration guarantees a bank is never read and written in the same cycle.
  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    logic [SRAM_WIDTH-1:0] mem [2**BANK_DEPTH_BIT];

    always_ff @(posedge clk) begin
      if (bank_we[b]) mem[wr_row] <= wr_data;
    end

    assign bank_word[b] = mem[rd_row];
  end

  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_ram_frmpool_banked.sv
// Scoreboard bench for ram_frmpool_banked: directed scenarios plus randomized traffic
// against a flat-memory reference model with loss counters.
module tb_ram_frmpool_banked;

  localparam int unsigned BANK_BIT  = 2;
  localparam int unsigned NB        = 2**BANK_BIT;
  localparam int unsigned DEPTH_BIT = 6;
  localparam int unsigned W         = 28;
  localparam int unsigned AB        = DEPTH_BIT + BANK_BIT;
  localparam int unsigned STARVE    = 3;
  localparam int unsigned CW        = 4;
  localparam bit          WR_PRI    = 1'b1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_req = 1'b0, rd_req = 1'b0;
  logic [AB-1:0] wr_addr = '0, rd_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_ready, rd_ready, rd_valid;
  logic [W-1:0]  rd_data;
  logic [CW-1:0] conflict_cnt;

  ram_frmpool_banked #(
    .BANK_BIT      (BANK_BIT),
    .BANK_DEPTH_BIT(DEPTH_BIT),
    .SRAM_WIDTH    (W),
    .WR_PRIORITY   (WR_PRI),
    .STARVE_MAX    (STARVE),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_req      (wr_req),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_req      (rd_req),
    .rd_ready    (rd_ready),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic [W-1:0] ref_mem [2**AB];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] last_rd = '0;
  int           rd_loss = 0, wr_loss = 0, ref_cnt = 0;
  bit           g_wr = 1'b0, g_rd = 1'b0;
  bit           seen_wr = 1'b0, seen_rd = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: predict grants at the falling edge, compare, advance the model, pass the rising edge.
  task automatic step();
    bit collide, wr_win, def_wr;
    int loser_loss;
    @(negedge clk);
    collide    = wr_req && rd_req && ((wr_addr % NB) == (rd_addr % NB));
    def_wr     = WR_PRI;
    loser_loss = def_wr ? rd_loss : wr_loss;
    wr_win     = (loser_loss == STARVE) ? !def_wr : def_wr;
    g_wr       = wr_req && (!collide || wr_win);
    g_rd       = rd_req && (!collide || !wr_win);
    seen_wr    = wr_ready;
    seen_rd    = rd_ready;
    chk("wr_ready", wr_ready, g_wr);
    chk("rd_ready", rd_ready, g_rd);
    chk("conflict_cnt", conflict_cnt, ref_cnt);
    if (collide && ref_cnt < 2**CW - 1) ref_cnt++;
    if (g_wr) wr_loss = 0; else if (collide && wr_loss < STARVE) wr_loss++;
    if (g_rd) rd_loss = 0; else if (collide && rd_loss < STARVE) rd_loss++;
    if (g_rd) exp_q.push_back(ref_mem[rd_addr]);
    if (g_wr) ref_mem[wr_addr] = wr_data;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_req = 1'b0;
    rd_req = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_conflict_cnt", conflict_cnt, 0);
    exp_q.delete();
    last_rd = '0;
    rd_loss = 0;
    wr_loss = 0;
    ref_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic write_word(input logic [AB-1:0] a, input logic [W-1:0] d);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    for (int i = 0; i < 16; i++) begin
      step();
      if (g_wr) break;
    end
    if (!g_wr) chk("wr_grant_timeout", seen_wr, 1);
    wr_req = 1'b0;
  endtask

  // Response monitor: each rising edge must produce exactly the responses the model queued.
  always begin
    @(posedge clk);
    #2;
    if (rst_n) begin
      chk("rd_valid", rd_valid, exp_q.size() != 0);
      if (rd_valid && exp_q.size() != 0) last_rd = exp_q.pop_front();
      chk("rd_data", rd_data, last_rd);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // preload every word so the model never holds unknowns
    for (int a = 0; a < 2**AB; a++) begin
      wr_req  = 1'b1;
      wr_addr = AB'(a);
      wr_data = W'($urandom);
      step();
    end
    wr_req = 1'b0;
    write_word(8'h04, 28'h1234567);
    write_word(8'h08, 28'h0000011);
    write_word(8'h10, 28'h0ABCDEF);

    // reset with a read response in flight
    rd_req  = 1'b1;
    rd_addr = 8'h04;
    step();
    rd_req = 1'b0;
    chk("pre_reset_valid", rd_valid, 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_idle_valid", rd_valid, 0);
    end

    // same-bank collision, same address
    wr_req = 1'b1; wr_addr = 8'h08; wr_data = 28'h0000055;
    rd_req = 1'b1; rd_addr = 8'h08;
    step();
    chk("coll_c0_wr_ready", seen_wr, 1);
    chk("coll_c0_rd_ready", seen_rd, 0);
    wr_req = 1'b0;
    step();
    chk("coll_c1_rd_ready", seen_rd, 1);
    rd_req = 1'b0;
    chk("coll_rd_data", rd_data, 28'h0000055);
    chk("coll_conflict_cnt", conflict_cnt, 1);

    // parallel access to different banks
    wr_req = 1'b1; wr_addr = 8'h05; wr_data = 28'hABCDEF0;
    rd_req = 1'b1; rd_addr = 8'h04;
    step();
    chk("dual_wr_ready", seen_wr, 1);
    chk("dual_rd_ready", seen_rd, 1);
    wr_req = 1'b0; rd_req = 1'b0;
    chk("dual_rd_data", rd_data, 28'h1234567);
    rd_req = 1'b1; rd_addr = 8'h05;
    step();
    rd_req = 1'b0;
    chk("dual_follow_data", rd_data, 28'hABCDEF0);

    // starvation override on bank 2
    wr_req = 1'b1; wr_addr = 8'h02; wr_data = W'($urandom);
    rd_req = 1'b1; rd_addr = 8'h06;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("starve_rd_ready", seen_rd, (i % 4) == 3);
      chk("starve_wr_ready", seen_wr, (i % 4) != 3);
      if (g_wr) begin
        wr_addr = wr_addr + AB'(NB);
        wr_data = W'($urandom);
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    step();

    // read hold across idle cycles
    rd_req = 1'b1; rd_addr = 8'h10;
    step();
    rd_req = 1'b0;
    chk("hold_first_valid", rd_valid, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_idle_valid", rd_valid, 0);
      chk("hold_idle_data", rd_data, 28'h0ABCDEF);
    end

    // conflict counter saturation
    do_reset();
    wr_req = 1'b1; wr_addr = 8'h01; wr_data = W'($urandom);
    rd_req = 1'b1; rd_addr = 8'h01;
    for (int i = 0; i < 20; i++) begin
      step();
      if (g_wr) begin
        wr_addr = wr_addr + AB'(NB);
        wr_data = W'($urandom);
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    step();
    chk("sat_conflict_cnt", conflict_cnt, 15);
    step();
    chk("sat_conflict_hold", conflict_cnt, 15);

    // randomized traffic with hold-until-ready and occasional abandonment
    for (int c = 0; c < 2000; c++) begin
      if (!wr_req || g_wr) begin
        wr_req  = ($urandom_range(0, 3) != 0);
        wr_addr = AB'($urandom_range(0, 15));
        wr_data = W'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        wr_req = 1'b0;
      end
      if (!rd_req || g_rd) begin
        rd_req  = ($urandom_range(0, 3) != 0);
        rd_addr = AB'($urandom_range(0, 15));
      end else if ($urandom_range(0, 15) == 0) begin
        rd_req = 1'b0;
      end
      step();
    end

    wr_req = 1'b0; rd_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("pending_reads", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
